// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared PIC10F200 constants: PC width, stack depth, CALL/RETLW opcodes
package pic_pkg;

  localparam int PC_WIDTH    = 9;
  localparam int STACK_DEPTH = 2;
  localparam int INSTR_WIDTH = 12;

  // 12-bit encodings: CALL = 1001_kkkk_kkkk, RETLW = 1000_kkkk_kkkk
  localparam logic [3:0] OPC_CALL  = 4'b1001;
  localparam logic [3:0] OPC_RETLW = 4'b1000;

  function automatic logic is_call(input logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1 -: 4] == OPC_CALL;
  endfunction

  function automatic logic is_retlw(input logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1 -: 4] == OPC_RETLW;
  endfunction

endpackage

// File: rtl/call_stack.sv
// rtl/call_stack.sv - PIC10F200 return-address stack with occupancy status
// Sticky overflow/underflow flags are built only when CALL_STACK_FLAGS_EN is defined.
module call_stack
  import pic_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stack_push,
  input  logic             stack_pop,
  input  logic [WIDTH-1:0] stack_in,
  input  logic             stack_flag_clr,
  output logic [WIDTH-1:0] stack_top,
  output logic [CW-1:0]    stack_count,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_ovf,
  output logic             stack_unf
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0] count_q, count_d;
  logic          is_empty, is_full;
  logic          ovf_set, unf_set;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (stack_push && !stack_pop) begin
      count_d = is_full ? count_q : count_q + ONE_C;
      ovf_set = is_full;
    end else if (stack_pop && !stack_push) begin
      count_d = is_empty ? '0 : count_q - ONE_C;
      unf_set = is_empty;
    end else if (stack_push && stack_pop) begin
      count_d = is_empty ? ONE_C : count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Combined push+pop only replaces the top; the bottom level survives a pop (PIC copy-up).
  for (genvar i = 0; i < DEPTH; i++) begin : lvl
    logic [WIDTH-1:0] ent_q, ent_d;

    if (i == 0) begin : g_top
      always_comb begin
        ent_d = ent_q;
        if (stack_push)     ent_d = stack_in;
        else if (stack_pop) ent_d = lvl[1].ent_q;
      end
    end else if (i == DEPTH - 1) begin : g_bot
      always_comb begin
        ent_d = ent_q;
        if (stack_push && !stack_pop) ent_d = lvl[i-1].ent_q;
      end
    end else begin : g_mid
      always_comb begin
        ent_d = ent_q;
        if (stack_push && !stack_pop)      ent_d = lvl[i-1].ent_q;
        else if (stack_pop && !stack_push) ent_d = lvl[i+1].ent_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) ent_q <= '0;
      else     ent_q <= ent_d;
    end
  end

  assign stack_top   = lvl[0].ent_q;
  assign stack_count = count_q;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;

`ifdef CALL_STACK_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A set event in the same cycle as a clear wins.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~stack_flag_clr);
    unf_d = unf_set | (unf_q & ~stack_flag_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  logic [2:0] unused_flag_sigs;
  assign unused_flag_sigs = {stack_flag_clr, ovf_set, unf_set};
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - directed self-checking bench for call_stack
module tb_call_stack;

`ifdef CALL_STACK_FLAGS_EN
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam logic EXP_FLAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       stack_push;
  logic       stack_pop;
  logic [8:0] stack_in;
  logic       stack_flag_clr;
  logic [8:0] stack_top;
  logic [1:0] stack_count;
  logic       stack_empty;
  logic       stack_full;
  logic       stack_ovf;
  logic       stack_unf;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  call_stack dut (
    .clk            (clk),
    .rst            (rst),
    .stack_push     (stack_push),
    .stack_pop      (stack_pop),
    .stack_in       (stack_in),
    .stack_flag_clr (stack_flag_clr),
    .stack_top      (stack_top),
    .stack_count    (stack_count),
    .stack_empty    (stack_empty),
    .stack_full     (stack_full),
    .stack_ovf      (stack_ovf),
    .stack_unf      (stack_unf)
  );

  // Apply one cycle of stimulus and sample #1 after the edge.
  task automatic cyc(input logic r, input logic pu, input logic po, input logic [8:0] din, input logic clr);
    rst = r; stack_push = pu; stack_pop = po; stack_in = din; stack_flag_clr = clr;
    @(posedge clk);
    #1;
    rst = 1'b0; stack_push = 1'b0; stack_pop = 1'b0; stack_in = '0; stack_flag_clr = 1'b0;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 9'h000, 0);
    cyc(1, 0, 0, 9'h000, 0);
    tests_run++; if (stack_top !== 9'h000) begin tests_failed++; $display("FAIL reset_top: got %h want 000", stack_top); end
    tests_run++; if (stack_count !== 2'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", stack_count); end
    tests_run++; if (stack_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", stack_empty); end
    tests_run++; if (stack_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", stack_full); end
    tests_run++; if ({stack_ovf, stack_unf} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b want 00", {stack_ovf, stack_unf}); end
  endtask

  task automatic test_push;
    cyc(1, 0, 0, 9'h000, 0);
    cyc(0, 1, 0, 9'h026, 0);
    tests_run++; if (stack_top !== 9'h026) begin tests_failed++; $display("FAIL push_top: got %h want 026", stack_top); end
    tests_run++; if (stack_count !== 2'd1) begin tests_failed++; $display("FAIL push_count: got %0d want 1", stack_count); end
    tests_run++; if (stack_empty !== 1'b0) begin tests_failed++; $display("FAIL push_empty: got %b want 0", stack_empty); end
    // idle cycle holds state
    cyc(0, 0, 0, 9'h1AA, 0);
    tests_run++; if ({stack_top, stack_count} !== {9'h026, 2'd1}) begin tests_failed++; $display("FAIL idle_hold: got %h/%0d want 026/1", stack_top, stack_count); end
  endtask

  task automatic test_overflow;
    cyc(1, 0, 0, 9'h000, 0);
    cyc(0, 1, 0, 9'h0A0, 0);
    cyc(0, 1, 0, 9'h1FF, 0);
    tests_run++; if (stack_top !== 9'h1FF) begin tests_failed++; $display("FAIL fill_top: got %h want 1FF", stack_top); end
    tests_run++; if ({stack_full, stack_count} !== {1'b1, 2'd2}) begin tests_failed++; $display("FAIL fill_full: got full=%b cnt=%0d want 1/2", stack_full, stack_count); end
    tests_run++; if (stack_ovf !== 1'b0) begin tests_failed++; $display("FAIL fill_no_ovf: got %b want 0", stack_ovf); end
    cyc(0, 1, 0, 9'h055, 0);
    tests_run++; if (stack_top !== 9'h055) begin tests_failed++; $display("FAIL ovf_top: got %h want 055", stack_top); end
    tests_run++; if (stack_count !== 2'd2) begin tests_failed++; $display("FAIL ovf_count: got %0d want 2", stack_count); end
    tests_run++; if (stack_ovf !== EXP_FLAG) begin tests_failed++; $display("FAIL ovf_flag: got %b want %b", stack_ovf, EXP_FLAG); end
    cyc(0, 0, 1, 9'h000, 0);
    tests_run++; if (stack_top !== 9'h1FF) begin tests_failed++; $display("FAIL ovf_e1: got %h want 1FF", stack_top); end
  endtask

  task automatic test_underflow;
    cyc(1, 0, 0, 9'h000, 0);
    cyc(0, 1, 0, 9'h0A0, 0);
    cyc(0, 1, 0, 9'h1FF, 0);
    cyc(0, 0, 1, 9'h000, 0);
    tests_run++; if ({stack_top, stack_count} !== {9'h0A0, 2'd1}) begin tests_failed++; $display("FAIL pop1: got %h/%0d want 0A0/1", stack_top, stack_count); end
    tests_run++; if (stack_full !== 1'b0) begin tests_failed++; $display("FAIL pop1_full: got %b want 0", stack_full); end
    cyc(0, 0, 1, 9'h000, 0);
    tests_run++; if ({stack_top, stack_count} !== {9'h0A0, 2'd0}) begin tests_failed++; $display("FAIL pop2: got %h/%0d want 0A0/0", stack_top, stack_count); end
    tests_run++; if ({stack_empty, stack_unf} !== 2'b10) begin tests_failed++; $display("FAIL pop2_empty: got empty=%b unf=%b want 1/0", stack_empty, stack_unf); end
    cyc(0, 0, 1, 9'h000, 0);
    tests_run++; if (stack_unf !== EXP_FLAG) begin tests_failed++; $display("FAIL unf_flag: got %b want %b", stack_unf, EXP_FLAG); end
    tests_run++; if ({stack_top, stack_count} !== {9'h0A0, 2'd0}) begin tests_failed++; $display("FAIL unf_state: got %h/%0d want 0A0/0", stack_top, stack_count); end
    tests_run++; if (stack_ovf !== 1'b0) begin tests_failed++; $display("FAIL unf_no_ovf: got %b want 0", stack_ovf); end
  endtask

  task automatic test_push_pop;
    cyc(1, 0, 0, 9'h000, 0);
    cyc(0, 1, 0, 9'h010, 0);
    cyc(0, 1, 1, 9'h123, 0);
    tests_run++; if ({stack_top, stack_count} !== {9'h123, 2'd1}) begin tests_failed++; $display("FAIL pp_cnt1: got %h/%0d want 123/1", stack_top, stack_count); end
    tests_run++; if ({stack_ovf, stack_unf} !== 2'b00) begin tests_failed++; $display("FAIL pp_flags: got %b want 00", {stack_ovf, stack_unf}); end
    // from empty: count becomes 1, no underflow
    cyc(1, 0, 0, 9'h000, 0);
    cyc(0, 1, 1, 9'h0C3, 0);
    tests_run++; if ({stack_top, stack_count, stack_unf} !== {9'h0C3, 2'd1, 1'b0}) begin tests_failed++; $display("FAIL pp_empty: got %h/%0d/%b want 0C3/1/0", stack_top, stack_count, stack_unf); end
    // from full: level 1 untouched, no overflow
    cyc(0, 1, 0, 9'h077, 0);
    cyc(0, 1, 1, 9'h188, 0);
    tests_run++; if ({stack_top, stack_count, stack_ovf} !== {9'h188, 2'd2, 1'b0}) begin tests_failed++; $display("FAIL pp_full: got %h/%0d/%b want 188/2/0", stack_top, stack_count, stack_ovf); end
    cyc(0, 0, 1, 9'h000, 0);
    tests_run++; if (stack_top !== 9'h0C3) begin tests_failed++; $display("FAIL pp_full_e1: got %h want 0C3", stack_top); end
  endtask

  task automatic test_flag_clr;
    cyc(1, 0, 0, 9'h000, 0);
    cyc(0, 1, 0, 9'h001, 0);
    cyc(0, 1, 0, 9'h002, 0);
    cyc(0, 1, 0, 9'h003, 0);
    tests_run++; if (stack_ovf !== EXP_FLAG) begin tests_failed++; $display("FAIL clr_pre: got %b want %b", stack_ovf, EXP_FLAG); end
    cyc(0, 0, 0, 9'h000, 1);
    tests_run++; if (stack_ovf !== 1'b0) begin tests_failed++; $display("FAIL clr_ovf: got %b want 0", stack_ovf); end
    tests_run++; if ({stack_top, stack_count} !== {9'h003, 2'd2}) begin tests_failed++; $display("FAIL clr_state: got %h/%0d want 003/2", stack_top, stack_count); end
    cyc(0, 1, 0, 9'h004, 1);
    tests_run++; if (stack_ovf !== EXP_FLAG) begin tests_failed++; $display("FAIL clr_set_wins: got %b want %b", stack_ovf, EXP_FLAG); end
    cyc(0, 0, 1, 9'h000, 0);
    cyc(0, 0, 1, 9'h000, 0);
    cyc(0, 0, 1, 9'h000, 0);
    tests_run++; if ({stack_ovf, stack_unf} !== {EXP_FLAG, EXP_FLAG}) begin tests_failed++; $display("FAIL both_flags: got %b want %b%b", {stack_ovf, stack_unf}, EXP_FLAG, EXP_FLAG); end
    cyc(0, 0, 0, 9'h000, 1);
    tests_run++; if ({stack_ovf, stack_unf} !== 2'b00) begin tests_failed++; $display("FAIL clr_both: got %b want 00", {stack_ovf, stack_unf}); end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, 9'h000, 0);
    cyc(0, 1, 0, 9'h011, 0);
    cyc(0, 1, 0, 9'h022, 0);
    cyc(0, 1, 0, 9'h033, 0);
    cyc(1, 1, 0, 9'h0FF, 0);
    tests_run++; if ({stack_top, stack_count} !== {9'h000, 2'd0}) begin tests_failed++; $display("FAIL rst_mid: got %h/%0d want 000/0", stack_top, stack_count); end
    tests_run++; if ({stack_empty, stack_ovf, stack_unf} !== 3'b100) begin tests_failed++; $display("FAIL rst_mid_status: got %b want 100", {stack_empty, stack_ovf, stack_unf}); end
    cyc(0, 0, 1, 9'h000, 0);
    tests_run++; if (stack_top !== 9'h000) begin tests_failed++; $display("FAIL rst_mid_e1: got %h want 000", stack_top); end
  endtask

  initial begin
    rst = 1'b1; stack_push = 1'b0; stack_pop = 1'b0; stack_in = '0; stack_flag_clr = 1'b0;
    test_reset;
    test_push;
    test_overflow;
    test_underflow;
    test_push_pop;
    test_flag_clr;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
